// File: rtl/tf_stage3_aligner_if.sv
// Bundle of the stage-3 aligner's streaming, provider and output signals.
// The aligner itself uses the slave modport; the surrounding environment uses master.
interface tf_stage3_aligner_if #(
    parameter int float_len = 32
);
    logic [2*float_len-1:0] din_data;
    logic                   din_valid;
    logic                   din_ready;
    logic                   tf_en;
    logic [2*float_len-1:0] tf_data;
    logic                   tf_valid;
    logic [2*float_len-1:0] dout_data;
    logic [2*float_len-1:0] dout_tf;
    logic                   dout_first;
    logic                   dout_last;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   err_align;

    modport slave (
        input  din_data, din_valid, tf_data, tf_valid, dout_ready,
        output din_ready, tf_en, dout_data, dout_tf, dout_first, dout_last,
               dout_valid, err_align
    );

    modport master (
        output din_data, din_valid, tf_data, tf_valid, dout_ready,
        input  din_ready, tf_en, dout_data, dout_tf, dout_first, dout_last,
               dout_valid, err_align
    );
endinterface

// File: rtl/tf_stage3_aligner.sv
// Pairs each accepted sample with the twiddle returned one cycle later and
// queues the pairs, tagged with frame first/last, in a small FWFT FIFO.
module tf_stage3_aligner #(
    parameter int float_len     = 32,
    parameter int bram_addr_len = 13,
    parameter int FIFO_DEPTH    = 4,
    parameter int FIFO_AW       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    tf_stage3_aligner_if.slave   io
);
    localparam int W = 2 * float_len;
    localparam logic [bram_addr_len-1:0] IDX_LAST  = '1;
    localparam logic [FIFO_AW+1:0]       DEPTH_OCC = (FIFO_AW+2)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]         DEPTH_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

    logic                     acc;
    logic                     ready;
    logic [FIFO_AW+1:0]       occupancy;
    logic                     s1_valid;
    logic                     s1_first;
    logic                     s1_last;
    logic [W-1:0]             s1_data;
    logic [bram_addr_len-1:0] idx;
    logic                     err_q;

    logic [W-1:0]             mem_data  [FIFO_DEPTH];
    logic [W-1:0]             mem_tf    [FIFO_DEPTH];
    logic                     mem_first [FIFO_DEPTH];
    logic                     mem_last  [FIFO_DEPTH];
    logic [FIFO_AW-1:0]       wr_ptr;
    logic [FIFO_AW-1:0]       rd_ptr;
    logic [FIFO_AW:0]         count;
    logic                     push;
    logic                     pop;
    logic                     not_empty;

    // Admission counts the pair still in s1 and ignores a same-cycle pop,
    // so a push can never land on a full FIFO.
    always_comb begin
        occupancy = {1'b0, count} + {{(FIFO_AW+1){1'b0}}, s1_valid};
        ready     = occupancy < DEPTH_OCC;
        acc       = io.din_valid & ready;
        not_empty = count != '0;
        push      = s1_valid;
        pop       = not_empty & io.dout_ready;
    end

    assign io.din_ready  = ready;
    assign io.tf_en      = acc;
    assign io.dout_valid = not_empty;
    assign io.dout_data  = mem_data[rd_ptr];
    assign io.dout_tf    = mem_tf[rd_ptr];
    assign io.dout_first = not_empty & mem_first[rd_ptr];
    assign io.dout_last  = not_empty & mem_last[rd_ptr];
    assign io.err_align  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            idx      <= '0;
            err_q    <= 1'b0;
        end else begin
            s1_valid <= acc;
            if (acc) begin
                idx <= idx + 1'b1;
            end
            if (s1_valid && !io.tf_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            s1_data  <= io.din_data;
            s1_first <= idx == '0;
            s1_last  <= idx == IDX_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= s1_data;
            mem_tf[wr_ptr]    <= io.tf_data;
            mem_first[wr_ptr] <= s1_first;
            mem_last[wr_ptr]  <= s1_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) !(push && count == DEPTH_CNT)
    );
endmodule
